regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (regWrite/writeReg/writeData) between two writeback requesters: ALU and MEM.
- Each requester has a valid/ready port and a small FIFO. A round-robin arbiter drains the FIFO heads into a registered write stage that drives the register file directly.
- A query port reports whether a write to a given register is still in flight, so issue logic can stall on read-after-write hazards.

Parameters:
- DATA_W, 64, write data width.
- ADDR_W, 5, register address width (32 registers).
- DEPTH, 2, entries per requester FIFO. Must be a power of 2 and >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- alu_valid  in  1  ALU write request valid.
- alu_ready  out  1  ALU FIFO can accept.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU write data.
- mem_valid  in  1  MEM write request valid.
- mem_ready  out  1  MEM FIFO can accept.
- mem_addr  in  ADDR_W  MEM destination register.
- mem_data  in  DATA_W  MEM write data.
- regWrite  out  1  register-file write enable.
- writeReg  out  ADDR_W  register-file write address.
- writeData  out  DATA_W  register-file write data.
- query_addr  in  ADDR_W  register to check for a pending write.
- query_pending  out  1  a write to query_addr is buffered or in the output stage.
- idle  out  1  both FIFOs empty and regWrite low.

Behaviour:
- Reset (rst_n low at a clk edge): FIFOs emptied, regWrite=0, writeReg=0, writeData=0, last_grant=MEM (so ALU wins the first tie), idle=1.
- Reset mid-operation discards all buffered requests and any write in the output stage. The output-stage write is not performed.
- Handshake:
  - A transfer occurs at an edge where valid && ready.
  - ready = rst_n && (count < DEPTH). It never depends on valid in the same cycle.
  - The requester holds addr/data stable while valid is high and ready is low.
  - Entries are accepted and drained in FIFO order per requester.
- Register 0: a request with addr==0 completes the handshake but is not enqueued. It never produces regWrite.
- Arbitration (combinational on FIFO heads each cycle):
  - Only one head valid: grant it.
  - Both heads valid: grant the requester other than last_grant.
  - last_grant updates at each edge where a grant occurs.
  - The granted head is popped at the same edge.
- Output stage (registered):
  - At an edge with a grant: regWrite<=1, writeReg<=head.addr, writeData<=head.data.
  - At an edge with no grant: regWrite<=0. writeReg/writeData hold their values.
  - Throughput is one write per cycle.
- Latency: handshake at edge E0 -> regWrite high during E1..E2 -> register file captures at E2, assuming no contention. A contended request waits one extra cycle per losing arbitration; the wait is bounded by 1 cycle, since the other requester can take only one consecutive grant while both are pending.
- Simultaneous enqueue and pop on the same FIFO in one edge is legal; count is unchanged.
- Ordering:
  - No ordering is guaranteed between ALU and MEM.
  - Writes to the same register from both requesters land in grant order; the last granted value wins.
- query_pending:
  - Combinational OR over both FIFOs' valid entries with addr==query_addr, plus (regWrite && writeReg==query_addr).
  - Forced to 0 when query_addr==0.
- idle = both FIFO counts 0 && !regWrite.

Decomposition:
- Package regfile_pkg:
  - ADDR_W/DATA_W constants.
  - wb_req_t struct {addr, data}.
  - wb_src_e enum {SRC_ALU, SRC_MEM}, used for last_grant.
- Sub-module wb_fifo (parameter DEPTH):
  - Ports: clk, rst_n, push, push_data wb_req_t, pop, head wb_req_t, empty, full, plus an entry-valid vector and address vector exposed for the query match.
  - Instantiated twice, once per requester.

Test Plan:
- Reset, then ALU sends addr=3 data=0xA5 at E0 -> regWrite=1, writeReg=3, writeData=0xA5 during E1..E2 only; idle returns to 1 after E2.
- ALU addr=5 and MEM addr=6 valid in the same cycle after reset -> ALU granted first (writeReg=5 at E1), MEM second (writeReg=6 at E2).
- Both requesters stream 4 requests back-to-back -> grants strictly alternate ALU, MEM, ALU, ...; each requester's addresses appear in issue order.
- Hold ALU FIFO full by stalling drain with continuous MEM traffic -> alu_ready=0 at count==DEPTH; ALU requests held under ready=0 are neither lost nor duplicated; regWrite pulse count equals the number of accepted requests.
- ALU addr=0 data=0xFF -> handshake completes, no regWrite pulse, query_pending stays 0.
- MEM enqueues addr=7, query_addr=7 -> query_pending=1 from E0 through the cycle regWrite is high; 0 afterwards. rst_n low mid-stream -> FIFOs empty, regWrite=0, query_pending=0 on the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, request payload and source encoding for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two valid/ready requesters, the register-file write port and the hazard query.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] query_addr;
  logic              query_pending;
  logic              idle;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  query_addr,
    output alu_ready, mem_ready,
    output regWrite, writeReg, writeData,
    output query_pending, idle
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output query_addr,
    input  alu_ready, mem_ready,
    input  regWrite, writeReg, writeData,
    input  query_pending, idle
  );

endinterface

// File: rtl/wb_fifo.sv
// Per-requester writeback FIFO; exposes per-entry valid bits and addresses for hazard matching.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  wb_req_t                        push_data,
  input  logic                           pop,
  output wb_req_t                        head,
  output logic                           empty,
  output logic                           full,
  output logic [DEPTH-1:0]               entry_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]   entry_addr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t          r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;

  // Entries fill and drain in ring order, so the valid vector alone gives empty/full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_addr[i] = r_mem[i].addr;
    end
  end

  assign head      = r_mem[r_rd_ptr];
  assign empty     = ~|r_vld;
  assign full      = &r_vld;
  assign entry_vld = r_vld;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port between ALU and MEM writeback FIFOs.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  wb_req_t                       w_alu_req;
  wb_req_t                       w_mem_req;
  wb_req_t                       w_alu_head;
  wb_req_t                       w_mem_head;
  wb_req_t                       w_win;
  logic                          w_alu_empty;
  logic                          w_alu_full;
  logic                          w_mem_empty;
  logic                          w_mem_full;
  logic                          w_alu_ready;
  logic                          w_mem_ready;
  logic                          w_alu_push;
  logic                          w_mem_push;
  logic                          w_grant_alu;
  logic                          w_grant_mem;
  logic                          w_grant;
  logic                          w_match;
  logic [DEPTH-1:0]              w_alu_vld;
  logic [DEPTH-1:0]              w_mem_vld;
  logic [DEPTH-1:0][ADDR_W-1:0]  w_alu_addrs;
  logic [DEPTH-1:0][ADDR_W-1:0]  w_mem_addrs;
  wb_src_e                       w_last_grant_nxt;

  wb_src_e                       r_last_grant;
  logic                          r_reg_write;
  logic [ADDR_W-1:0]             r_write_reg;
  logic [DATA_W-1:0]             r_write_data;

  assign w_alu_ready = rst_n && !w_alu_full;
  assign w_mem_ready = rst_n && !w_mem_full;

  // Writes to register 0 complete the handshake but are dropped here.
  assign w_alu_push = bus.alu_valid && w_alu_ready && (bus.alu_addr != '0);
  assign w_mem_push = bus.mem_valid && w_mem_ready && (bus.mem_addr != '0);
  assign w_alu_req  = '{addr: bus.alu_addr, data: bus.alu_data};
  assign w_mem_req  = '{addr: bus.mem_addr, data: bus.mem_data};

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_alu_push),
    .push_data  (w_alu_req),
    .pop        (w_grant_alu),
    .head       (w_alu_head),
    .empty      (w_alu_empty),
    .full       (w_alu_full),
    .entry_vld  (w_alu_vld),
    .entry_addr (w_alu_addrs)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_mem_push),
    .push_data  (w_mem_req),
    .pop        (w_grant_mem),
    .head       (w_mem_head),
    .empty      (w_mem_empty),
    .full       (w_mem_full),
    .entry_vld  (w_mem_vld),
    .entry_addr (w_mem_addrs)
  );

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    w_grant_alu      = 1'b0;
    w_grant_mem      = 1'b0;
    w_last_grant_nxt = r_last_grant;
    if (!w_alu_empty && !w_mem_empty) begin
      if (r_last_grant == SRC_MEM) w_grant_alu = 1'b1;
      else                         w_grant_mem = 1'b1;
    end else if (!w_alu_empty) begin
      w_grant_alu = 1'b1;
    end else if (!w_mem_empty) begin
      w_grant_mem = 1'b1;
    end
    if (w_grant_alu)      w_last_grant_nxt = SRC_ALU;
    else if (w_grant_mem) w_last_grant_nxt = SRC_MEM;
  end

  assign w_grant = w_grant_alu || w_grant_mem;
  assign w_win   = w_grant_alu ? w_alu_head : w_mem_head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= SRC_MEM;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_last_grant <= w_last_grant_nxt;
      r_reg_write  <= w_grant;
      if (w_grant) begin
        r_write_reg  <= w_win.addr;
        r_write_data <= w_win.data;
      end
    end
  end

  // A register is busy while any buffered entry or the output stage targets it.
  always_comb begin
    w_match = r_reg_write && (r_write_reg == bus.query_addr);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_alu_vld[i] && (w_alu_addrs[i] == bus.query_addr)) w_match = 1'b1;
      if (w_mem_vld[i] && (w_mem_addrs[i] == bus.query_addr)) w_match = 1'b1;
    end
  end

  assign bus.alu_ready     = w_alu_ready;
  assign bus.mem_ready     = w_mem_ready;
  assign bus.regWrite      = r_reg_write;
  assign bus.writeReg      = r_write_reg;
  assign bus.writeData     = r_write_data;
  assign bus.query_pending = w_match && (bus.query_addr != '0);
  assign bus.idle          = w_alu_empty && w_mem_empty && !r_reg_write;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: cycle table plus scoreboarded streaming sequences.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam logic [DATA_W-1:0] MT = {1'b1, {(DATA_W-1){1'b0}}};

  typedef struct {
    logic              rst;
    logic              av;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ad;
    logic              mv;
    logic [ADDR_W-1:0] ma;
    logic [DATA_W-1:0] md;
    logic [ADDR_W-1:0] q;
    logic              e_rw;
    logic [ADDR_W-1:0] e_wr;
    logic [DATA_W-1:0] e_wd;
    logic              e_qp;
    logic              e_idle;
    logic              e_ar;
    logic              e_mr;
  } vec_t;

  logic    clk   = 1'b0;
  logic    rst_n = 1'b0;
  int      n_checks = 0;
  int      n_errors = 0;
  int      n_wr  = 0;
  int      n_acc = 0;
  bit      saw_alu_low = 1'b0;
  wb_req_t alu_q[$];
  wb_req_t mem_q[$];
  logic    grant_log[$];
  wb_req_t mon_got;
  wb_req_t mon_exp;
  vec_t    tbl [11];

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_bound(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no completion, expected one within the cycle bound", nm);
  endtask

  // Scoreboard: handshakes enqueue expectations, register-file writes pop and compare them.
  always @(negedge clk) begin
    if (!rst_n) begin
      alu_q.delete();
      mem_q.delete();
    end else begin
      if (bus.regWrite) begin
        n_wr++;
        mon_got = '{addr: bus.writeReg, data: bus.writeData};
        grant_log.push_back(bus.writeData[DATA_W-1]);
        if (bus.writeData[DATA_W-1]) begin
          if (mem_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_mem_extra: got write reg %0d data %0h, expected no MEM write", mon_got.addr, mon_got.data);
          end else begin
            mon_exp = mem_q.pop_front();
            chk("sb_mem_addr", DATA_W'(mon_got.addr), DATA_W'(mon_exp.addr));
            chk("sb_mem_data", mon_got.data, mon_exp.data);
          end
        end else begin
          if (alu_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_alu_extra: got write reg %0d data %0h, expected no ALU write", mon_got.addr, mon_got.data);
          end else begin
            mon_exp = alu_q.pop_front();
            chk("sb_alu_addr", DATA_W'(mon_got.addr), DATA_W'(mon_exp.addr));
            chk("sb_alu_data", mon_got.data, mon_exp.data);
          end
        end
      end
      if (bus.alu_valid && bus.alu_ready && (bus.alu_addr != '0)) begin
        alu_q.push_back('{addr: bus.alu_addr, data: bus.alu_data});
        n_acc++;
      end
      if (bus.mem_valid && bus.mem_ready && (bus.mem_addr != '0)) begin
        mem_q.push_back('{addr: bus.mem_addr, data: bus.mem_data});
        n_acc++;
      end
      if (bus.alu_valid && !bus.alu_ready) saw_alu_low = 1'b1;
    end
  end

  task automatic send(input bit is_mem, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit done;
    done = 1'b0;
    if (is_mem) begin
      bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_data = d;
    end else begin
      bus.alu_valid = 1'b1; bus.alu_addr = a; bus.alu_data = d;
    end
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      done = is_mem ? bus.mem_ready : bus.alu_ready;
      @(posedge clk);
      #1;
    end
    if (!done) fail_bound(is_mem ? "send_mem" : "send_alu");
    if (is_mem) bus.mem_valid = 1'b0;
    else        bus.alu_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge clk);
      #1;
      ok = bus.idle;
    end
    if (!ok) fail_bound(nm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int w0;
    int a0;
    //         rst   av    aa     ad       mv    ma     md          q      e_rw  e_wr   e_wd        e_qp  e_idle e_ar e_mr
    tbl[0]  = '{1'b1, 1'b1, 5'd3,  64'hA5,  1'b0, 5'd0,  64'h0,      5'd3,  1'b0, 5'd0,  64'h0,      1'b1, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 5'd0,  64'h0,   1'b0, 5'd0,  64'h0,      5'd3,  1'b1, 5'd3,  64'hA5,     1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 5'd0,  64'h0,   1'b0, 5'd0,  64'h0,      5'd3,  1'b0, 5'd3,  64'hA5,     1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 5'd0,  64'h0,   1'b0, 5'd0,  64'h0,      5'd3,  1'b0, 5'd0,  64'h0,      1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 5'd5,  64'h55,  1'b1, 5'd6,  MT|64'h66,  5'd6,  1'b0, 5'd0,  64'h0,      1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 5'd0,  64'h0,   1'b0, 5'd0,  64'h0,      5'd6,  1'b1, 5'd5,  64'h55,     1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 5'd0,  64'h0,   1'b0, 5'd0,  64'h0,      5'd5,  1'b1, 5'd6,  MT|64'h66,  1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 5'd0,  64'hFF,  1'b0, 5'd0,  64'h0,      5'd0,  1'b0, 5'd6,  MT|64'h66,  1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 5'd0,  64'h0,   1'b1, 5'd7,  MT|64'h77,  5'd7,  1'b0, 5'd6,  MT|64'h66,  1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 5'd0,  64'h0,   1'b0, 5'd0,  64'h0,      5'd7,  1'b1, 5'd7,  MT|64'h77,  1'b1, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 5'd0,  64'h0,   1'b0, 5'd0,  64'h0,      5'd7,  1'b0, 5'd7,  MT|64'h77,  1'b0, 1'b1, 1'b1, 1'b1};

    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.query_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_regWrite",  DATA_W'(bus.regWrite), '0);
    chk("reset_writeReg",  DATA_W'(bus.writeReg), '0);
    chk("reset_writeData", bus.writeData, '0);
    chk("reset_idle",      DATA_W'(bus.idle), DATA_W'(1));

    for (int i = 0; i < 11; i++) begin
      rst_n          = tbl[i].rst;
      bus.alu_valid  = tbl[i].av; bus.alu_addr = tbl[i].aa; bus.alu_data = tbl[i].ad;
      bus.mem_valid  = tbl[i].mv; bus.mem_addr = tbl[i].ma; bus.mem_data = tbl[i].md;
      bus.query_addr = tbl[i].q;
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_regWrite", i),  DATA_W'(bus.regWrite),      DATA_W'(tbl[i].e_rw));
      chk($sformatf("t%0d_writeReg", i),  DATA_W'(bus.writeReg),      DATA_W'(tbl[i].e_wr));
      chk($sformatf("t%0d_writeData", i), bus.writeData,              tbl[i].e_wd);
      chk($sformatf("t%0d_query", i),     DATA_W'(bus.query_pending), DATA_W'(tbl[i].e_qp));
      chk($sformatf("t%0d_idle", i),      DATA_W'(bus.idle),          DATA_W'(tbl[i].e_idle));
      chk($sformatf("t%0d_alu_ready", i), DATA_W'(bus.alu_ready),     DATA_W'(tbl[i].e_ar));
      chk($sformatf("t%0d_mem_ready", i), DATA_W'(bus.mem_ready),     DATA_W'(tbl[i].e_mr));
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    rst_n = 1'b1;

    // Both requesters streaming from reset: grants must alternate starting with ALU.
    do_reset();
    grant_log.delete();
    fork
      for (int k = 0; k < 4; k++) send(1'b0, ADDR_W'(8 + k), DATA_W'(k + 1));
      for (int k = 0; k < 4; k++) send(1'b1, ADDR_W'(16 + k), MT | DATA_W'(k + 16));
    join
    wait_idle("stream_drain");
    chk("stream_grant_count", DATA_W'(grant_log.size()), DATA_W'(8));
    for (int k = 0; k < grant_log.size() && k < 8; k++)
      chk($sformatf("stream_alternate_%0d", k), DATA_W'(grant_log[k]), DATA_W'(k % 2));

    // Sustained traffic on both sides fills the ALU FIFO and exercises held requests.
    saw_alu_low = 1'b0;
    w0 = n_wr;
    a0 = n_acc;
    fork
      for (int k = 0; k < 8; k++)  send(1'b0, ADDR_W'(20 + k), DATA_W'(256 + k));
      for (int k = 0; k < 12; k++) send(1'b1, ADDR_W'(1 + k), MT | DATA_W'(k));
    join
    wait_idle("backpressure_drain");
    chk("alu_backpressure_seen", DATA_W'(saw_alu_low), DATA_W'(1));
    chk("accepted_count",        DATA_W'(n_acc - a0), DATA_W'(20));
    chk("pulses_eq_accepted",    DATA_W'(n_wr - w0), DATA_W'(n_acc - a0));
    chk("drain_alu_q_empty",     DATA_W'(alu_q.size()), '0);
    chk("drain_mem_q_empty",     DATA_W'(mem_q.size()), '0);

    // Reset with one write in the output stage and one still buffered.
    bus.query_addr = 5'd9;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 64'h99;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = MT | 64'h99;
    @(posedge clk);
    #1;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_regWrite_before", DATA_W'(bus.regWrite), DATA_W'(1));
    chk("midrst_query_before",    DATA_W'(bus.query_pending), DATA_W'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_regWrite",  DATA_W'(bus.regWrite), '0);
    chk("midrst_query",     DATA_W'(bus.query_pending), '0);
    chk("midrst_idle",      DATA_W'(bus.idle), DATA_W'(1));
    chk("midrst_alu_ready", DATA_W'(bus.alu_ready), '0);
    chk("midrst_mem_ready", DATA_W'(bus.mem_ready), '0);
    rst_n = 1'b1;
    w0 = n_wr;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_late_write", DATA_W'(n_wr - w0), '0);
    chk("midrst_still_idle",    DATA_W'(bus.idle), DATA_W'(1));

    chk("final_alu_q_empty", DATA_W'(alu_q.size()), '0);
    chk("final_mem_q_empty", DATA_W'(mem_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
